// File: rtl/toggle_en_gen.sv
// ============================================================================
// Module      : toggle_en_gen
// Description : Push-button front end for a T flip-flop enable. Synchronises
//               the raw button, debounces press and release, and emits one
//               single-cycle en pulse per accepted press, with optional
//               auto-repeat while the button stays held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_en_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic rep_en,
  output logic en,
  output logic held
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_DEB_PRESS = 3'd1;
  localparam logic [2:0] c_PRESSED   = 3'd2;
  localparam logic [2:0] c_REPEAT    = 3'd3;
  localparam logic [2:0] c_DEB_REL   = 3'd4;

  // Terminal counts: a counter value of N-1 marks the N-th qualifying edge.
  localparam logic [CNT_W-1:0] c_ZERO     = '0;
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_btn_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_en;
  logic             r_held;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_en_nxt;
  logic             w_held_nxt;

  // Two-flop synchroniser: the raw button is asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_btn_s <= r_sync1;
    end
  end

  // Next-state logic: the synchronised button level always takes priority
  // over counter expiry and the repeat enable.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_en_nxt    = 1'b0;

    case (r_state)
      c_IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = c_DEB_PRESS;
          w_cnt_nxt   = c_ONE;
        end
      end

      c_DEB_PRESS: begin
        if (!r_btn_s) begin
          // Press bounce: give up silently.
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = c_ZERO;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = c_PRESSED;
          w_en_nxt    = 1'b1;
          w_hcnt_nxt  = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end

      c_PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = c_DEB_REL;
          w_cnt_nxt   = c_ONE;
        end else if (!rep_en) begin
          w_hcnt_nxt  = c_ZERO;
        end else if (r_hcnt == c_HLD_LAST) begin
          w_state_nxt = c_REPEAT;
          w_en_nxt    = 1'b1;
          w_hcnt_nxt  = c_ZERO;
        end else begin
          w_hcnt_nxt  = r_hcnt + c_ONE;
        end
      end

      c_REPEAT: begin
        if (!r_btn_s) begin
          w_state_nxt = c_DEB_REL;
          w_cnt_nxt   = c_ONE;
        end else if (!rep_en) begin
          // Leaving repeat restarts the full initial hold delay.
          w_state_nxt = c_PRESSED;
          w_hcnt_nxt  = c_ZERO;
        end else if (r_hcnt == c_REP_LAST) begin
          w_en_nxt    = 1'b1;
          w_hcnt_nxt  = c_ZERO;
        end else begin
          w_hcnt_nxt  = r_hcnt + c_ONE;
        end
      end

      c_DEB_REL: begin
        if (r_btn_s) begin
          // Release bounce: still pressed, no new pulse, hold delay restarts.
          w_state_nxt = c_PRESSED;
          w_hcnt_nxt  = c_ZERO;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle.
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = c_ZERO;
        w_hcnt_nxt  = c_ZERO;
      end
    endcase

    // Held tracks the accepted press, including the release-debounce window.
    w_held_nxt = (w_state_nxt == c_PRESSED) ||
                 (w_state_nxt == c_REPEAT)  ||
                 (w_state_nxt == c_DEB_REL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= c_ZERO;
      r_hcnt  <= c_ZERO;
      r_en    <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_en    <= w_en_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign en   = r_en;
  assign held = r_held;

endmodule

`default_nettype wire

// File: tb/tb_toggle_en_gen.sv
// ============================================================================
// Module      : tb_toggle_en_gen
// Description : Self-checking bench for toggle_en_gen. A run-length model of
//               the debounce and hold/repeat rules predicts en and held every
//               cycle; directed scenarios also check absolute pulse timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_en_gen;

  localparam int DB   = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;
  localparam int W    = 8;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic btn    = 1'b0;
  logic rep_en = 1'b0;
  logic en;
  logic held;

  always #5 clk = ~clk;

  toggle_en_gen #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .rep_en(rep_en),
    .en    (en),
    .held  (held)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;
  int t0       = 0;
  int fall_rel = -1;
  int pulses[$];
  logic prev_held = 1'b0;

  // Reference model: two-sample delay line, accepted level, length of the
  // current run of samples disagreeing with it, and edges since the last
  // repeat anchor.
  int m_s1, m_s2, m_lvl, m_run, m_e, m_first, m_en, m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
    m_e = 0; m_first = 1; m_en = 0; m_held = 0;
  endtask

  task automatic model_step(input int b, input int r);
    int bs;
    bs   = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    m_en = 0;
    if (m_lvl == 0) begin
      // Need DB consecutive high samples to accept a press.
      if (bs != 0) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = 1; m_run = 0; m_en = 1; m_e = 0; m_first = 1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (bs == 0) begin
        // Need DB consecutive low samples to accept a release.
        m_run++;
        if (m_run == DB) begin
          m_lvl = 0; m_run = 0;
        end
      end else if (m_run != 0) begin
        // Interrupted release: restart from the initial hold delay.
        m_run = 0; m_e = 0; m_first = 1;
      end else if (r == 0) begin
        m_e = 0; m_first = 1;
      end else begin
        m_e++;
        if (m_e == (m_first != 0 ? HOLD : REP)) begin
          m_en = 1; m_e = 0; m_first = 0;
        end
      end
    end
    m_held = m_lvl;
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn    = b;
    rep_en = r;
    @(posedge clk);
    edge_no++;
    if (!reset) model_reset();
    else        model_step(int'(b), int'(r));
    #1;
    check("en",   {31'd0, en},   m_en[31:0]);
    check("held", {31'd0, held}, m_held[31:0]);
    if (en === 1'b1) pulses.push_back(edge_no - t0);
    if (prev_held === 1'b1 && held === 1'b0) fall_rel = edge_no - t0;
    prev_held = held;
  endtask

  task automatic run(input logic b, input int n, input logic r);
    for (int i = 0; i < n; i++) step(b, r);
  endtask

  task automatic mark();
    t0 = edge_no;
    pulses.delete();
    fall_rel = -1;
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear at once.
  task automatic async_reset(input int n);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_en_imm",   {31'd0, en},   32'd0);
    check("rst_held_imm", {31'd0, held}, 32'd0);
    model_reset();
    prev_held = 1'b0;
    run(1'b1, n, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    int exp_rep[6];
    int seg_len;
    logic lvl;
    logic rv;
    exp_rep = '{6, 22, 30, 38, 46, 54};
    model_reset();

    // Reset held with button pressed, then release with button still high.
    run(1'b1, 5, 1'b0);
    reset = 1'b1;
    mark();
    run(1'b1, 10, 1'b0);
    check("rst_press_count", pulses.size(), 1);
    if (pulses.size() > 0) check("rst_press_edge", pulses[0], 6);

    // Clean press held 50 cycles, then released.
    run(1'b1, 40, 1'b0);
    check("hold_no_extra", pulses.size(), 1);
    mark();
    run(1'b0, 10, 1'b0);
    check("release_no_pulse", pulses.size(), 0);
    check("release_held_fall", fall_rel, 6);

    // Press bounce shorter than debounce window.
    mark();
    run(1'b1, 3, 1'b0);
    run(1'b0, 10, 1'b0);
    check("press_bounce", pulses.size(), 0);

    // Auto-repeat at default timing.
    run(1'b0, 5, 1'b1);
    mark();
    run(1'b1, 56, 1'b1);
    run(1'b0, 10, 1'b1);
    check("repeat_count", pulses.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < pulses.size()) check("repeat_edge", pulses[i], exp_rep[i]);

    // Release bounce while pressed.
    run(1'b1, 12, 1'b0);
    mark();
    run(1'b0, 2, 1'b0);
    run(1'b1, 10, 1'b0);
    check("release_bounce", pulses.size(), 0);
    check("release_bounce_held", {31'd0, held}, 32'd1);

    // rep_en dropped mid-repeat, then raised again.
    run(1'b1, 30, 1'b1);
    mark();
    run(1'b1, 12, 1'b0);
    check("rep_drop_quiet", pulses.size(), 0);
    mark();
    run(1'b1, 20, 1'b1);
    check("rep_resume_count", pulses.size(), 1);
    if (pulses.size() > 0) check("rep_resume_edge", pulses[0], 16);
    run(1'b0, 10, 1'b0);

    // Reset mid-press: new press must take the full sync plus debounce.
    run(1'b1, 10, 1'b0);
    async_reset(3);
    mark();
    run(1'b1, 10, 1'b0);
    check("rst_mid_count", pulses.size(), 1);
    if (pulses.size() > 0) check("rst_mid_edge", pulses[0], 6);
    run(1'b0, 10, 1'b0);

    // Randomised segments with bounce and rep_en changes.
    lvl = 1'b0;
    rv  = 1'b0;
    for (int s = 0; s < 150; s++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 3) == 0) rv = ~rv;
      if ($urandom_range(0, 2) == 0) seg_len = $urandom_range(1, DB + 1);
      else                           seg_len = $urandom_range(1, 45);
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(0, 19) == 0) rv = ~rv;
        step(lvl, rv);
      end
      if (s == 75) async_reset($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
